// File: rtl/bht_update_gen.sv
// In-order FIFO of issued branch predictions. Each resolution pops the head and returns one registered training update.
// Optional BHT_UPD_STATS_EN adds saturating update/mispredict counters.
module bht_update_gen #(
    parameter int DEPTH  = 8,
    parameter int VLEN   = 39,
    parameter int GIDX_W = 10,
    parameter int LIDX_W = 10,
    parameter int MD_W   = GIDX_W + LIDX_W + 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     debug_mode_i,
    input  logic                     pred_valid_i,
    output logic                     pred_ready_o,
    input  logic [VLEN-1:0]          pred_pc_i,
    input  logic                     pred_taken_i,
    input  logic [MD_W-1:0]          pred_metadata_i,
    input  logic                     res_valid_i,
    input  logic                     res_taken_i,
    output logic                     upd_valid_o,
    output logic [VLEN-1:0]          upd_pc_o,
    output logic                     upd_taken_o,
    output logic [MD_W-1:0]          upd_metadata_o,
    output logic                     upd_mispredict_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     err_o
`ifdef BHT_UPD_STATS_EN
    ,
    output logic [31:0]              stat_upd_o,
    output logic [31:0]              stat_mispred_o
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [VLEN-1:0] pc_mem [DEPTH];
    logic            tk_mem [DEPTH];
    logic [MD_W-1:0] md_mem [DEPTH];

    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            err_q, err_d;
    logic            upd_valid_q, upd_valid_d;
    logic [VLEN-1:0] upd_pc_q, upd_pc_d;
    logic            upd_taken_q, upd_taken_d;
    logic [MD_W-1:0] upd_md_q, upd_md_d;
    logic            upd_mis_q, upd_mis_d;

    logic full, empty, push, pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    // An empty FIFO never bypasses a same-cycle push to the resolve side.
    assign push  = pred_valid_i & ~full;
    assign pop   = res_valid_i & ~empty;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q + CW'(push) - CW'(pop);
        err_d       = err_q | (pred_valid_i & full) | (res_valid_i & empty);
        upd_valid_d = 1'b0;
        upd_mis_d   = 1'b0;
        upd_pc_d    = upd_pc_q;
        upd_taken_d = upd_taken_q;
        upd_md_d    = upd_md_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d    = rd_ptr_q + PW'(1);
            upd_valid_d = ~debug_mode_i;
            upd_pc_d    = pc_mem[rd_ptr_q];
            upd_md_d    = md_mem[rd_ptr_q];
            upd_taken_d = res_taken_i;
            upd_mis_d   = res_taken_i ^ tk_mem[rd_ptr_q];
        end
        // Flush discards the cycle's push/pop, so neither can raise an error.
        if (flush_i) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            err_d       = err_q;
            upd_valid_d = 1'b0;
            upd_mis_d   = 1'b0;
            upd_pc_d    = '0;
            upd_taken_d = 1'b0;
            upd_md_d    = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            err_q       <= 1'b0;
            upd_valid_q <= 1'b0;
            upd_pc_q    <= '0;
            upd_taken_q <= 1'b0;
            upd_md_q    <= '0;
            upd_mis_q   <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            err_q       <= err_d;
            upd_valid_q <= upd_valid_d;
            upd_pc_q    <= upd_pc_d;
            upd_taken_q <= upd_taken_d;
            upd_md_q    <= upd_md_d;
            upd_mis_q   <= upd_mis_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push && !rst_i && !flush_i) begin
            pc_mem[wr_ptr_q] <= pred_pc_i;
            tk_mem[wr_ptr_q] <= pred_taken_i;
            md_mem[wr_ptr_q] <= pred_metadata_i;
        end
    end

    assign pred_ready_o     = ~full;
    assign count_o          = count_q;
    assign err_o            = err_q;
    assign upd_valid_o      = upd_valid_q;
    assign upd_pc_o         = upd_pc_q;
    assign upd_taken_o      = upd_taken_q;
    assign upd_metadata_o   = upd_md_q;
    assign upd_mispredict_o = upd_mis_q;

`ifdef BHT_UPD_STATS_EN
    logic [31:0] stat_upd_q, stat_mispred_q;

    // Counters sample the registered pulse, so they trail upd_valid_o by one cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stat_upd_q     <= '0;
            stat_mispred_q <= '0;
        end else begin
            if (upd_valid_q && stat_upd_q != 32'hFFFF_FFFF) begin
                stat_upd_q <= stat_upd_q + 32'd1;
            end
            if (upd_valid_q && upd_mis_q && stat_mispred_q != 32'hFFFF_FFFF) begin
                stat_mispred_q <= stat_mispred_q + 32'd1;
            end
        end
    end

    assign stat_upd_o     = stat_upd_q;
    assign stat_mispred_o = stat_mispred_q;
`endif
endmodule

// File: tb/tb_bht_update_gen.sv
// Directed bench for bht_update_gen: vector table plus sequences for full, wrap, flush and stats.
module tb_bht_update_gen;
    logic        clk = 1'b0;
    logic        rst, flush, dbg, pv, pt, rv, rt;
    logic [38:0] pc;
    logic [23:0] md;
    logic        ready, uv, ut, mis, err;
    logic [38:0] upc;
    logic [23:0] umd;
    logic [3:0]  cnt;
`ifdef BHT_UPD_STATS_EN
    logic [31:0] st_upd, st_mis;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    bht_update_gen dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .debug_mode_i(dbg),
        .pred_valid_i(pv), .pred_ready_o(ready), .pred_pc_i(pc),
        .pred_taken_i(pt), .pred_metadata_i(md),
        .res_valid_i(rv), .res_taken_i(rt),
        .upd_valid_o(uv), .upd_pc_o(upc), .upd_taken_o(ut),
        .upd_metadata_o(umd), .upd_mispredict_o(mis),
        .count_o(cnt), .err_o(err)
`ifdef BHT_UPD_STATS_EN
        , .stat_upd_o(st_upd), .stat_mispred_o(st_mis)
`endif
    );

    typedef struct {
        logic        pv;
        logic [38:0] pc;
        logic        pt;
        logic [23:0] md;
        logic        rv;
        logic        rt;
        logic        dbg;
        logic        fl;
        logic        e_uv;
        logic [38:0] e_pc;
        logic        e_ut;
        logic [23:0] e_md;
        logic        e_mis;
        logic [3:0]  e_cnt;
        logic        e_err;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        pv = 1'b0; pc = '0; pt = 1'b0; md = '0;
        rv = 1'b0; rt = 1'b0; dbg = 1'b0; flush = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic push(input int p, input logic t, input int m);
        pv = 1'b1; pc = 39'(p); pt = t; md = 24'(m);
        tick();
        pv = 1'b0;
    endtask

    initial begin
        // pv pc pt md rv rt dbg fl | uv pc ut md mis cnt err
        vecs[0]  = '{1'b1, 39'h1000, 1'b1, 24'hABCDE, 1'b0, 1'b0, 1'b0, 1'b0,
                     1'b0, 39'h0,    1'b0, 24'h0,     1'b0, 4'd1, 1'b0};
        vecs[1]  = '{1'b0, 39'h0,    1'b0, 24'h0,     1'b1, 1'b0, 1'b0, 1'b0,
                     1'b1, 39'h1000, 1'b0, 24'hABCDE, 1'b1, 4'd0, 1'b0};
        vecs[2]  = '{1'b0, 39'h0,    1'b0, 24'h0,     1'b0, 1'b0, 1'b0, 1'b0,
                     1'b0, 39'h1000, 1'b0, 24'hABCDE, 1'b0, 4'd0, 1'b0};
        vecs[3]  = '{1'b1, 39'h2000, 1'b0, 24'h11111, 1'b0, 1'b0, 1'b1, 1'b0,
                     1'b0, 39'h1000, 1'b0, 24'hABCDE, 1'b0, 4'd1, 1'b0};
        vecs[4]  = '{1'b1, 39'h2004, 1'b1, 24'h22222, 1'b0, 1'b0, 1'b1, 1'b0,
                     1'b0, 39'h1000, 1'b0, 24'hABCDE, 1'b0, 4'd2, 1'b0};
        vecs[5]  = '{1'b0, 39'h0,    1'b0, 24'h0,     1'b1, 1'b0, 1'b1, 1'b0,
                     1'b0, 39'h2000, 1'b0, 24'h11111, 1'b0, 4'd1, 1'b0};
        vecs[6]  = '{1'b0, 39'h0,    1'b0, 24'h0,     1'b1, 1'b1, 1'b1, 1'b0,
                     1'b0, 39'h2004, 1'b1, 24'h22222, 1'b0, 4'd0, 1'b0};
        vecs[7]  = '{1'b0, 39'h0,    1'b0, 24'h0,     1'b1, 1'b0, 1'b0, 1'b0,
                     1'b0, 39'h2004, 1'b1, 24'h22222, 1'b0, 4'd0, 1'b1};
        vecs[8]  = '{1'b1, 39'h3000, 1'b0, 24'h33333, 1'b0, 1'b0, 1'b0, 1'b0,
                     1'b0, 39'h2004, 1'b1, 24'h22222, 1'b0, 4'd1, 1'b1};
        vecs[9]  = '{1'b1, 39'h3004, 1'b1, 24'h44444, 1'b0, 1'b0, 1'b0, 1'b0,
                     1'b0, 39'h2004, 1'b1, 24'h22222, 1'b0, 4'd2, 1'b1};
        vecs[10] = '{1'b1, 39'h3008, 1'b0, 24'h55555, 1'b1, 1'b1, 1'b0, 1'b0,
                     1'b1, 39'h3000, 1'b1, 24'h33333, 1'b1, 4'd2, 1'b1};
        vecs[11] = '{1'b1, 39'h300C, 1'b0, 24'h66666, 1'b1, 1'b1, 1'b0, 1'b1,
                     1'b0, 39'h0,    1'b0, 24'h0,     1'b0, 4'd0, 1'b1};
        vecs[12] = '{1'b0, 39'h0,    1'b0, 24'h0,     1'b1, 1'b0, 1'b0, 1'b0,
                     1'b0, 39'h0,    1'b0, 24'h0,     1'b0, 4'd0, 1'b1};

        do_reset();
        chk("rst_count", 64'(cnt), 64'd0);
        chk("rst_ready", 64'(ready), 64'd1);
        chk("rst_uv", 64'(uv), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_pc", 64'(upc), 64'd0);

        for (int i = 0; i < 13; i++) begin
            pv = vecs[i].pv; pc = vecs[i].pc; pt = vecs[i].pt; md = vecs[i].md;
            rv = vecs[i].rv; rt = vecs[i].rt; dbg = vecs[i].dbg; flush = vecs[i].fl;
            tick();
            chk($sformatf("v%0d_uv", i), 64'(uv), 64'(vecs[i].e_uv));
            chk($sformatf("v%0d_pc", i), 64'(upc), 64'(vecs[i].e_pc));
            chk($sformatf("v%0d_taken", i), 64'(ut), 64'(vecs[i].e_ut));
            chk($sformatf("v%0d_md", i), 64'(umd), 64'(vecs[i].e_md));
            chk($sformatf("v%0d_mis", i), 64'(mis), 64'(vecs[i].e_mis));
            chk($sformatf("v%0d_count", i), 64'(cnt), 64'(vecs[i].e_cnt));
            chk($sformatf("v%0d_err", i), 64'(err), 64'(vecs[i].e_err));
        end
        idle();
        do_reset();
        chk("rst_clears_err", 64'(err), 64'd0);

        // Fill, overflow, drain in order
        for (int i = 0; i < 8; i++) push(32'h4000 + 4 * i, 1'b1, i);
        chk("full_count", 64'(cnt), 64'd8);
        chk("full_ready", 64'(ready), 64'd0);
        chk("full_err", 64'(err), 64'd0);
        push(32'h4FFF, 1'b0, 24'hFFFFF);
        chk("ovf_count", 64'(cnt), 64'd8);
        chk("ovf_err", 64'(err), 64'd1);
        for (int i = 0; i < 8; i++) begin
            rv = 1'b1; rt = 1'(i % 2);
            tick();
            chk($sformatf("drain%0d_uv", i), 64'(uv), 64'd1);
            chk($sformatf("drain%0d_pc", i), 64'(upc), 64'(32'h4000 + 4 * i));
            chk($sformatf("drain%0d_md", i), 64'(umd), 64'(i));
            chk($sformatf("drain%0d_mis", i), 64'(mis), 64'((i % 2) == 0));
            chk($sformatf("drain%0d_count", i), 64'(cnt), 64'(7 - i));
        end
        idle();
        tick();
        chk("drain_idle_uv", 64'(uv), 64'd0);

        // Push and resolve together on an empty FIFO: no bypass
        do_reset();
        pv = 1'b1; pc = 39'h7000; rv = 1'b1;
        tick();
        idle();
        chk("nobypass_uv", 64'(uv), 64'd0);
        chk("nobypass_count", 64'(cnt), 64'd1);
        chk("nobypass_err", 64'(err), 64'd1);

        // Steady push+resolve at count 3 across pointer wrap
        do_reset();
        for (int i = 0; i < 3; i++) push(32'h5000 + 4 * i, 1'b0, 0);
        for (int k = 0; k < 7; k++) begin
            pv = 1'b1; pc = 39'(32'h5000 + 4 * (3 + k)); pt = 1'b0;
            rv = 1'b1; rt = 1'b0;
            tick();
            chk($sformatf("wrap%0d_count", k), 64'(cnt), 64'd3);
            chk($sformatf("wrap%0d_pc", k), 64'(upc), 64'(32'h5000 + 4 * k));
            chk($sformatf("wrap%0d_uv", k), 64'(uv), 64'd1);
        end
        idle();
        for (int k = 7; k < 10; k++) begin
            rv = 1'b1;
            tick();
            chk($sformatf("wrapd%0d_pc", k), 64'(upc), 64'(32'h5000 + 4 * k));
            chk($sformatf("wrapd%0d_count", k), 64'(cnt), 64'(9 - k));
        end
        idle();

        // Flush with 5 entries and same-cycle push+resolve; err must hold
        do_reset();
        rv = 1'b1;
        tick();
        idle();
        chk("uflow_uv", 64'(uv), 64'd0);
        chk("uflow_err", 64'(err), 64'd1);
        for (int i = 0; i < 5; i++) push(32'h6000 + 4 * i, 1'b1, i);
        chk("preflush_count", 64'(cnt), 64'd5);
        pv = 1'b1; pc = 39'h6100; rv = 1'b1; flush = 1'b1;
        tick();
        idle();
        chk("flush_count", 64'(cnt), 64'd0);
        chk("flush_uv", 64'(uv), 64'd0);
        chk("flush_err", 64'(err), 64'd1);
        tick();
        chk("postflush_uv", 64'(uv), 64'd0);
        chk("postflush_count", 64'(cnt), 64'd0);

`ifdef BHT_UPD_STATS_EN
        do_reset();
        chk("stat_rst_upd", 64'(st_upd), 64'd0);
        for (int i = 0; i < 10; i++) begin
            push(32'h8000 + 4 * i, 1'b1, i);
            rv = 1'b1; rt = (i < 4) ? 1'b0 : 1'b1;
            tick();
            rv = 1'b0;
        end
        tick();
        tick();
        chk("stat_upd", 64'(st_upd), 64'd10);
        chk("stat_mis", 64'(st_mis), 64'd4);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        chk("stat_flush_upd", 64'(st_upd), 64'd10);
        chk("stat_flush_mis", 64'(st_mis), 64'd4);
        do_reset();
        chk("stat_clr_upd", 64'(st_upd), 64'd0);
        chk("stat_clr_mis", 64'(st_mis), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
